// File: rtl/ours_axi4_b_resp_demux.sv
// B-channel return path: buffers downstream write responses and routes each beat to the port
// named by its info word. Define OURS_B_DEMUX_OUTSTANDING_CHK_EN for per-port outstanding tracking.
module ours_axi4_b_resp_demux #(
    parameter int BACKEND_DOMAIN = 0,
    parameter int N_INPUT        = 2,
    parameter int B_WIDTH        = 8,
    parameter int PORT_ID_LSB    = 2,
    parameter int BUF_DEPTH_B    = 2,
    parameter int CNT_W          = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       master_bvld,
    input  logic [B_WIDTH-1:0]         master_b,
    output logic                       master_brdy,
    output logic [N_INPUT-1:0]         slave_bvld,
    output logic [N_INPUT*B_WIDTH-1:0] slave_b,
    input  logic [N_INPUT-1:0]         slave_brdy,
    input  logic [N_INPUT-1:0]         slave_aw_hs,
    output logic [N_INPUT-1:0]         aw_stall,
    output logic                       orphan_err,
    output logic                       clk_en
);

    localparam int PORT_ID_W  = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam int PTR_W      = (BUF_DEPTH_B > 1) ? $clog2(BUF_DEPTH_B) : 1;
    localparam int FILL_W     = $clog2(BUF_DEPTH_B + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(BUF_DEPTH_B - 1);
    localparam logic [FILL_W-1:0] DEPTH_FILL = FILL_W'(BUF_DEPTH_B);

    generate
        if (N_INPUT < 1 || N_INPUT > 16 || BUF_DEPTH_B < 1 || BACKEND_DOMAIN < 0) begin : g_param_err
            $error("ours_axi4_b_resp_demux: illegal parameter combination");
        end
    endgenerate

    logic [B_WIDTH-1:0]   mem [BUF_DEPTH_B];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [FILL_W-1:0]    fill;
    logic [B_WIDTH-1:0]   head;
    logic                 head_vld;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 legal;
    logic                 in_range;
    logic                 brdy_sel;
    logic [PORT_ID_W-1:0] sel;
    logic [4:0]           sel_ext;

    assign head_vld    = (fill != '0);
    assign master_brdy = (fill != DEPTH_FILL);
    assign push        = master_bvld & master_brdy;
    assign head        = mem[rd_ptr];
    assign sel         = head[PORT_ID_LSB +: PORT_ID_W];
    assign sel_ext     = 5'(sel);
    assign in_range    = (sel_ext < 5'(N_INPUT));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= master_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push & ~pop) begin
                fill <= fill + 1'b1;
            end else if (pop & ~push) begin
                fill <= fill - 1'b1;
            end
        end
    end

    // Illegal heads are discarded without ever presenting a valid to any port.
    always_comb begin
        slave_bvld = '0;
        brdy_sel   = 1'b0;
        for (int i = 0; i < N_INPUT; i++) begin
            if (sel_ext == 5'(i)) begin
                slave_bvld[i] = head_vld & legal;
                brdy_sel      = slave_brdy[i];
            end
        end
    end

    assign drop       = head_vld & ~legal;
    assign pop        = drop | (head_vld & legal & brdy_sel);
    assign orphan_err = drop;
    assign slave_b    = {N_INPUT{head}};

`ifdef OURS_B_DEMUX_OUTSTANDING_CHK_EN
    logic [CNT_W-1:0]   cnt [N_INPUT];
    logic [CNT_W-1:0]   cnt_sel;
    logic [N_INPUT-1:0] dec;
    logic               cnt_busy;

    always_comb begin
        cnt_sel  = '0;
        cnt_busy = 1'b0;
        dec      = '0;
        aw_stall = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            if (sel_ext == 5'(i)) begin
                cnt_sel = cnt[i];
            end
            if (cnt[i] != '0) begin
                cnt_busy = 1'b1;
            end
            aw_stall[i] = (cnt[i] == '1);
            dec[i]      = head_vld & legal & brdy_sel & (sel_ext == 5'(i));
        end
    end

    assign legal = in_range & (cnt_sel != '0);

    // A simultaneous issue and retire cancels even at saturation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_INPUT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_INPUT; i++) begin
                if (slave_aw_hs[i] & ~dec[i] & ~aw_stall[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec[i] & ~slave_aw_hs[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign clk_en = ~rstn | master_bvld | head_vld | (|slave_aw_hs) | cnt_busy;
`else
    logic unused_aw_hs;

    assign unused_aw_hs = ^slave_aw_hs;
    assign legal        = in_range;
    assign aw_stall     = '0;
    assign clk_en       = ~rstn | master_bvld | head_vld;
`endif

endmodule

// File: tb/tb_ours_axi4_b_resp_demux.sv
// Self-checking bench for ours_axi4_b_resp_demux: directed scenarios plus randomized traffic
// compared against a queue-based response model. Works with or without OURS_B_DEMUX_OUTSTANDING_CHK_EN.
module tb_ours_axi4_b_resp_demux;

    localparam int N     = 3;
    localparam int BW    = 8;
    localparam int LSB   = 2;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef OURS_B_DEMUX_OUTSTANDING_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            master_bvld = 1'b0;
    logic [BW-1:0]   master_b = '0;
    logic            master_brdy;
    logic [N-1:0]    slave_bvld;
    logic [N*BW-1:0] slave_b;
    logic [N-1:0]    slave_brdy = '0;
    logic [N-1:0]    slave_aw_hs = '0;
    logic [N-1:0]    aw_stall;
    logic            orphan_err;
    logic            clk_en;

    ours_axi4_b_resp_demux #(
        .BACKEND_DOMAIN(0), .N_INPUT(N), .B_WIDTH(BW),
        .PORT_ID_LSB(LSB), .BUF_DEPTH_B(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .master_bvld(master_bvld), .master_b(master_b), .master_brdy(master_brdy),
        .slave_bvld(slave_bvld), .slave_b(slave_b), .slave_brdy(slave_brdy),
        .slave_aw_hs(slave_aw_hs), .aw_stall(aw_stall),
        .orphan_err(orphan_err), .clk_en(clk_en)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] q[$];
    int            cnt[N];

    logic [N-1:0]  exp_bvld;
    logic [N-1:0]  exp_stall;
    logic          exp_brdy;
    logic          exp_orphan;
    logic          exp_clk_en;
    logic [BW-1:0] exp_head;
    int            exp_sel;
    bit            exp_legal;

    function automatic void compute();
        bit busy;
        exp_brdy   = (q.size() < DEPTH);
        exp_bvld   = '0;
        exp_orphan = 1'b0;
        exp_legal  = 1'b0;
        exp_sel    = 0;
        exp_head   = '0;
        if (q.size() > 0) begin
            exp_head = q[0];
            exp_sel  = int'(exp_head[LSB +: 2]);
            if (exp_sel < N) begin
                exp_legal = CHK ? (cnt[exp_sel] > 0) : 1'b1;
            end
            if (exp_legal) exp_bvld[exp_sel] = 1'b1;
            else exp_orphan = 1'b1;
        end
        busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_stall[i] = CHK && (cnt[i] == MAXC);
            if (cnt[i] != 0) busy = 1'b1;
        end
        exp_clk_en = master_bvld | (q.size() > 0);
        if (CHK) exp_clk_en = exp_clk_en | (|slave_aw_hs) | busy;
    endfunction

    task automatic drive(input logic bv, input logic [BW-1:0] b,
                         input logic [N-1:0] br, input logic [N-1:0] hs);
        master_bvld = bv;
        master_b    = b;
        slave_brdy  = br;
        slave_aw_hs = hs;
        compute();
        @(negedge clk);
    endtask

    task automatic advance();
        bit pop, push, dec;
        @(posedge clk);
        pop  = (q.size() > 0) && (!exp_legal || slave_brdy[exp_sel]);
        push = master_bvld && exp_brdy;
        if (CHK) begin
            for (int i = 0; i < N; i++) begin
                dec = pop && exp_legal && (exp_sel == i);
                if (slave_aw_hs[i] && dec) ;
                else if (slave_aw_hs[i] && cnt[i] < MAXC) cnt[i]++;
                else if (dec) cnt[i]--;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(master_b);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            drive(1'b0, '0, '1, '0);
            advance();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (slave_bvld !== '0) begin errors++; $display("FAIL reset_bvld: got %b expected 000", slave_bvld); end
        checks++;
        if (orphan_err !== 1'b0 || aw_stall !== '0) begin
            errors++; $display("FAIL reset_err_stall: got orphan=%b stall=%b expected 0/000", orphan_err, aw_stall);
        end
        checks++;
        if (clk_en !== 1'b1) begin errors++; $display("FAIL reset_clk_en: got %b expected 1", clk_en); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0);
        checks++;
        if (master_brdy !== 1'b1) begin errors++; $display("FAIL idle_brdy: got %b expected 1", master_brdy); end
        checks++;
        if (slave_bvld !== '0 || orphan_err !== 1'b0) begin
            errors++; $display("FAIL idle_outputs: got bvld=%b orphan=%b expected 000/0", slave_bvld, orphan_err);
        end
        checks++;
        if (clk_en !== 1'b0) begin errors++; $display("FAIL idle_clk_en: got %b expected 0", clk_en); end
        advance();
    endtask

    task automatic test_route();
        drive(1'b0, '0, '0, 3'b010);
        checks++;
        if (clk_en !== exp_clk_en) begin errors++; $display("FAIL route_clk_en: got %b expected %b", clk_en, exp_clk_en); end
        advance();
        drive(1'b1, 8'h05, '0, '0);
        checks++;
        if (slave_bvld !== 3'b000) begin errors++; $display("FAIL route_no_comb: got %b expected 000", slave_bvld); end
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (slave_bvld !== 3'b010) begin errors++; $display("FAIL route_bvld: got %b expected 010", slave_bvld); end
        checks++;
        if (slave_b[BW +: BW] !== 8'h05) begin errors++; $display("FAIL route_info: got %h expected 05", slave_b[BW +: BW]); end
        advance();
        drive(1'b0, '0, 3'b010, '0);
        checks++;
        if (slave_bvld !== 3'b010) begin errors++; $display("FAIL route_hold: got %b expected 010", slave_bvld); end
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (slave_bvld !== 3'b000) begin errors++; $display("FAIL route_popped: got %b expected 000", slave_bvld); end
        advance();
        // counter1 is back to zero, so a second response for port1 is an orphan when tracking is on
        drive(1'b1, 8'h06, '0, '0);
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (orphan_err !== exp_orphan || slave_bvld !== exp_bvld) begin
            errors++; $display("FAIL route_recheck: got orphan=%b bvld=%b expected %b/%b", orphan_err, slave_bvld, exp_orphan, exp_bvld);
        end
        advance();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 3'b001);
            advance();
        end
        drive(1'b1, 8'h10, '0, '0);
        advance();
        drive(1'b1, 8'h20, '0, '0);
        checks++;
        if (master_brdy !== 1'b1) begin errors++; $display("FAIL bp_brdy2: got %b expected 1", master_brdy); end
        advance();
        drive(1'b1, 8'h30, '0, '0);
        checks++;
        if (master_brdy !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", master_brdy); end
        advance();
        drive(1'b1, 8'h30, 3'b001, '0);
        checks++;
        if (slave_bvld !== 3'b001 || slave_b[0 +: BW] !== 8'h10) begin
            errors++; $display("FAIL bp_first: got bvld=%b info=%h expected 001/10", slave_bvld, slave_b[0 +: BW]);
        end
        advance();
        drive(1'b1, 8'h30, 3'b001, '0);
        checks++;
        if (master_brdy !== 1'b1 || slave_b[0 +: BW] !== 8'h20) begin
            errors++; $display("FAIL bp_second: got brdy=%b info=%h expected 1/20", master_brdy, slave_b[0 +: BW]);
        end
        advance();
        drive(1'b0, '0, 3'b001, '0);
        checks++;
        if (slave_bvld !== 3'b001 || slave_b[0 +: BW] !== 8'h30) begin
            errors++; $display("FAIL bp_third: got bvld=%b info=%h expected 001/30", slave_bvld, slave_b[0 +: BW]);
        end
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (slave_bvld !== 3'b000 || master_brdy !== 1'b1) begin
            errors++; $display("FAIL bp_empty: got bvld=%b brdy=%b expected 000/1", slave_bvld, master_brdy);
        end
        advance();
    endtask

    task automatic test_orphan();
        drive(1'b1, 8'h41, '0, '0);
        advance();
        drive(1'b0, '0, '0, '0);
`ifdef OURS_B_DEMUX_OUTSTANDING_CHK_EN
        checks++;
        if (slave_bvld !== 3'b000 || orphan_err !== 1'b1) begin
            errors++; $display("FAIL orphan_zero_cnt: got bvld=%b orphan=%b expected 000/1", slave_bvld, orphan_err);
        end
`else
        checks++;
        if (slave_bvld !== 3'b001 || orphan_err !== 1'b0) begin
            errors++; $display("FAIL orphan_delivered: got bvld=%b orphan=%b expected 001/0", slave_bvld, orphan_err);
        end
`endif
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (orphan_err !== 1'b0) begin errors++; $display("FAIL orphan_pulse: got %b expected 0", orphan_err); end
        advance();
        drain();
        drive(1'b1, 8'h0C, '0, '0);
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (slave_bvld !== 3'b000 || orphan_err !== 1'b1) begin
            errors++; $display("FAIL orphan_range: got bvld=%b orphan=%b expected 000/1", slave_bvld, orphan_err);
        end
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (orphan_err !== 1'b0 || clk_en !== exp_clk_en) begin
            errors++; $display("FAIL orphan_range_done: got orphan=%b clk_en=%b expected 0/%b", orphan_err, clk_en, exp_clk_en);
        end
        advance();
    endtask

    task automatic test_stall();
        for (int k = 0; k < MAXC + 1; k++) begin
            drive(1'b0, '0, '0, 3'b001);
            checks++;
            if (aw_stall !== exp_stall) begin errors++; $display("FAIL stall_fill%0d: got %b expected %b", k, aw_stall, exp_stall); end
            advance();
        end
        drive(1'b1, 8'h00, '0, '0);
        checks++;
        if (aw_stall[0] !== CHK) begin errors++; $display("FAIL stall_max: got %b expected %b", aw_stall[0], CHK); end
        advance();
        drive(1'b0, '0, 3'b001, 3'b001);
        checks++;
        if (slave_bvld !== 3'b001) begin errors++; $display("FAIL stall_pop: got %b expected 001", slave_bvld); end
        advance();
        drive(1'b1, 8'h00, '0, '0);
        checks++;
        if (aw_stall[0] !== CHK) begin errors++; $display("FAIL stall_cancel: got %b expected %b", aw_stall[0], CHK); end
        advance();
        drive(1'b0, '0, 3'b001, '0);
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (aw_stall !== 3'b000) begin errors++; $display("FAIL stall_release: got %b expected 000", aw_stall); end
        advance();
        for (int k = 0; k < MAXC - 1; k++) begin
            drive(1'b1, 8'h00, 3'b001, '0);
            advance();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h04, '0, 3'b011);
        advance();
        drive(1'b1, 8'h08, '0, '0);
        advance();
        master_bvld = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (slave_bvld !== '0 || master_brdy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_bvld_brdy: got %b/%b expected 000/1", slave_bvld, master_brdy);
        end
        checks++;
        if (aw_stall !== '0 || orphan_err !== 1'b0 || clk_en !== 1'b1) begin
            errors++; $display("FAIL rst_mid_misc: got stall=%b orphan=%b clk_en=%b expected 000/0/1", aw_stall, orphan_err, clk_en);
        end
        q.delete();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0);
        checks++;
        if (slave_bvld !== '0 || clk_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: got bvld=%b clk_en=%b expected 000/0", slave_bvld, clk_en);
        end
        advance();
        drive(1'b1, 8'h04, '0, '0);
        advance();
        drive(1'b0, '0, '0, '0);
        checks++;
        if (orphan_err !== exp_orphan) begin
            errors++; $display("FAIL rst_mid_cnt_cleared: got orphan=%b expected %b", orphan_err, exp_orphan);
        end
        advance();
        drain();
    endtask

    task automatic test_random();
        logic [BW-1:0] b;
        logic [N-1:0]  hs;
        for (int c = 0; c < 400; c++) begin
            b = BW'($urandom);
            for (int i = 0; i < N; i++) hs[i] = ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 2) != 0), b, N'($urandom), hs);
            checks++;
            if (slave_bvld !== exp_bvld) begin errors++; $display("FAIL rnd_bvld c%0d: got %b expected %b", c, slave_bvld, exp_bvld); end
            checks++;
            if (master_brdy !== exp_brdy) begin errors++; $display("FAIL rnd_brdy c%0d: got %b expected %b", c, master_brdy, exp_brdy); end
            checks++;
            if (orphan_err !== exp_orphan) begin errors++; $display("FAIL rnd_orphan c%0d: got %b expected %b", c, orphan_err, exp_orphan); end
            checks++;
            if (aw_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, aw_stall, exp_stall); end
            checks++;
            if (clk_en !== exp_clk_en) begin errors++; $display("FAIL rnd_clk_en c%0d: got %b expected %b", c, clk_en, exp_clk_en); end
            if (exp_bvld != '0) begin
                checks++;
                if (slave_b[exp_sel*BW +: BW] !== exp_head) begin
                    errors++; $display("FAIL rnd_info c%0d: got %h expected %h", c, slave_b[exp_sel*BW +: BW], exp_head);
                end
            end
            advance();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        test_reset();
        test_route();
        test_back_to_back();
        test_orphan();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
